// File: rtl/ladybug_input_cond.sv
// Lady Bug input conditioner: sync + debounce of raw joystick words, 4-way direction
// arbitration, queued coin pulse shaping, and pause / pause-dim control.
module ladybug_input_cond #(
  parameter int DEBOUNCE_CYC   = 20000,
  parameter int COIN_PULSE_CYC = 1000000,
  parameter int COIN_GAP_CYC   = 1000000,
  parameter int DIM_CYC        = 200000000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] joy1,
  input  logic [7:0] joy2,
  input  logic       hs_access,
  input  logic       osd_status,
  input  logic       osd_pause_en,
  output logic [3:0] dir1,
  output logic [3:0] dir2,
  output logic       start1,
  output logic       start2,
  output logic       coin,
  output logic [2:0] coin_pend,
  output logic       pause,
  output logic       dim
);

  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int PW  = $clog2(COIN_PULSE_CYC + 1);
  localparam int GW  = $clog2(COIN_GAP_CYC + 1);
  localparam int CW  = (PW > GW) ? PW : GW;
  localparam int DMW = $clog2(DIM_CYC + 1);

  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_GAP} coin_state_t;

  logic [15:0]    raw, s1, s2, db, db_prev;
  logic [DBW-1:0] db_cnt [16];

  assign raw = {joy2, joy1};

  // Each bit's counter only runs while the synced value disagrees with the accepted one.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      db      <= '0;
      db_prev <= '0;
      for (int i = 0; i < 16; i++) db_cnt[i] <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      db_prev <= db;
      for (int i = 0; i < 16; i++) begin
        if (s2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DEBOUNCE_CYC - 1)) begin
          db[i]     <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  function automatic logic [3:0] top_bit(input logic [3:0] v);
    if (v[3])      return 4'b1000;
    else if (v[2]) return 4'b0100;
    else if (v[1]) return 4'b0010;
    else if (v[0]) return 4'b0001;
    else           return 4'b0000;
  endfunction

  // A fresh press wins; otherwise keep the current direction until it is released.
  function automatic logic [3:0] next_dir(input logic [3:0] d, input logic [3:0] dp,
                                          input logic [3:0] cur);
    logic [3:0] rise;
    rise = d & ~dp;
    if (rise != 4'b0000)          return top_bit(rise);
    else if ((cur & d) == 4'b0000) return top_bit(d);
    else                          return cur;
  endfunction

  logic           coin_edge, pause_edge, pause_user;
  logic [DMW-1:0] dim_cnt;

  assign coin_edge  = (db[6] | db[14]) & ~(db_prev[6] | db_prev[14]);
  assign pause_edge = (db[7] | db[15]) & ~(db_prev[7] | db_prev[15]);
  assign dim        = (dim_cnt == DMW'(DIM_CYC));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dir1       <= '0;
      dir2       <= '0;
      start1     <= 1'b0;
      start2     <= 1'b0;
      pause_user <= 1'b0;
      pause      <= 1'b0;
      dim_cnt    <= '0;
    end else begin
      dir1       <= next_dir(db[3:0],  db_prev[3:0],  dir1);
      dir2       <= next_dir(db[11:8], db_prev[11:8], dir2);
      start1     <= db[4] | db[12];
      start2     <= db[5] | db[13];
      pause_user <= pause_user ^ pause_edge;
      pause      <= pause_user | hs_access | (osd_status & osd_pause_en);
      if (!pause)                       dim_cnt <= '0;
      else if (dim_cnt < DMW'(DIM_CYC)) dim_cnt <= dim_cnt + DMW'(1);
    end
  end

  coin_state_t   cst, cst_n;
  logic [CW-1:0] ccnt, ccnt_n;
  logic          coin_n, deq;
  logic [2:0]    pend_n;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cst       <= C_IDLE;
      ccnt      <= '0;
      coin      <= 1'b0;
      coin_pend <= '0;
    end else begin
      cst       <= cst_n;
      ccnt      <= ccnt_n;
      coin      <= coin_n;
      coin_pend <= pend_n;
    end
  end

  always_comb begin
    cst_n  = cst;
    ccnt_n = ccnt;
    coin_n = coin;
    deq    = 1'b0;
    case (cst)
      C_IDLE: begin
        if (coin_pend != 3'd0) begin
          cst_n  = C_PULSE;
          ccnt_n = '0;
          coin_n = 1'b1;
          deq    = 1'b1;
        end
      end
      C_PULSE: begin
        if (ccnt == CW'(COIN_PULSE_CYC - 1)) begin
          cst_n  = C_GAP;
          ccnt_n = '0;
          coin_n = 1'b0;
        end else begin
          ccnt_n = ccnt + CW'(1);
        end
      end
      C_GAP: begin
        if (ccnt == CW'(COIN_GAP_CYC - 1)) begin
          cst_n  = C_IDLE;
          ccnt_n = '0;
        end else begin
          ccnt_n = ccnt + CW'(1);
        end
      end
      default: begin
        cst_n  = C_IDLE;
        ccnt_n = '0;
        coin_n = 1'b0;
      end
    endcase
    // Simultaneous enqueue/dequeue leaves the count alone, even when full.
    pend_n = coin_pend;
    if (coin_edge && !deq && coin_pend != 3'd7) pend_n = coin_pend + 3'd1;
    else if (deq && !coin_edge)                 pend_n = coin_pend - 3'd1;
  end

endmodule

// File: tb/tb_ladybug_input_cond.sv
// Bench for ladybug_input_cond: directed scenarios plus random joystick traffic, all
// checked every cycle against a behavioural model of the conditioner.
module tb_ladybug_input_cond;
  localparam int DEB = 4, PUL = 8, GAP = 6, DIM = 20;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [7:0] joy1, joy2;
  logic       hs_access, osd_status, osd_pause_en;
  logic [3:0] dir1, dir2;
  logic       start1, start2, coin, pause, dim;
  logic [2:0] coin_pend;

  ladybug_input_cond #(.DEBOUNCE_CYC(DEB), .COIN_PULSE_CYC(PUL), .COIN_GAP_CYC(GAP),
                       .DIM_CYC(DIM)) dut (
    .clk_sys(clk_sys), .reset(reset), .joy1(joy1), .joy2(joy2), .hs_access(hs_access),
    .osd_status(osd_status), .osd_pause_en(osd_pause_en), .dir1(dir1), .dir2(dir2),
    .start1(start1), .start2(start2), .coin(coin), .coin_pend(coin_pend),
    .pause(pause), .dim(dim));

  always #5 clk_sys = ~clk_sys;

  // ---------------- behavioural model ----------------
  logic [15:0] dly0 = '0, dly1 = '0, m_db = '0, m_dprev = '0;
  int          nd [16];
  int          sel [2] = '{-1, -1};
  logic        m_start1 = 1'b0, m_start2 = 1'b0, pu = 1'b0, m_pause = 1'b0;
  int          pend = 0, since = -1, dcnt = 0;

  function automatic int hi(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int s);
    logic [3:0] one;
    one = 4'b0001;
    return (s < 0) ? 4'b0000 : (one << s);
  endfunction

  always @(posedge clk_sys) begin : model
    logic [3:0] d, rise;
    logic       cedge, pedge, deq;
    if (reset) begin
      dly0 = '0; dly1 = '0; m_db = '0; m_dprev = '0;
      for (int i = 0; i < 16; i++) nd[i] = 0;
      sel[0] = -1; sel[1] = -1;
      m_start1 = 1'b0; m_start2 = 1'b0; pu = 1'b0; m_pause = 1'b0;
      pend = 0; since = -1; dcnt = 0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        d    = m_db[p*8 +: 4];
        rise = d & ~m_dprev[p*8 +: 4];
        if (rise != 0) sel[p] = hi(rise);
        else if (sel[p] < 0 || !d[sel[p]]) sel[p] = hi(d);
      end
      m_start1 = m_db[4] | m_db[12];
      m_start2 = m_db[5] | m_db[13];
      cedge = (m_db[6] | m_db[14]) & ~(m_dprev[6] | m_dprev[14]);
      pedge = (m_db[7] | m_db[15]) & ~(m_dprev[7] | m_dprev[15]);
      // coin timeline: 'since' = cycles since the current pulse started, -1 when idle
      deq = (since < 0) && (pend > 0);
      if (deq) since = 0;
      else if (since >= 0) begin
        since++;
        if (since >= PUL + GAP) since = -1;
      end
      if (cedge && !deq) pend = (pend < 7) ? pend + 1 : 7;
      else if (deq && !cedge) pend--;
      dcnt = m_pause ? ((dcnt < DIM) ? dcnt + 1 : DIM) : 0;
      m_pause = pu | hs_access | (osd_status & osd_pause_en);
      pu ^= pedge;
      m_dprev = m_db;
      for (int i = 0; i < 16; i++) begin
        if (dly1[i] == m_db[i]) nd[i] = 0;
        else begin
          nd[i]++;
          if (nd[i] == DEB) begin m_db[i] = dly1[i]; nd[i] = 0; end
        end
      end
      dly1 = dly0;
      dly0 = {joy2, joy1};
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  int n_pulses = 0, bad_len = 0, hi_len = 0, lo_len = 100, mx = 0;
  logic coin_prev = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every wait goes through here: compare all outputs with the model, track coin shape.
  task automatic tick();
    logic [15:0] exp;
    @(negedge clk_sys);
    if (chk_en) begin
      exp = {onehot(sel[0]), onehot(sel[1]), m_start1, m_start2,
             (since >= 0 && since < PUL), 3'(pend), m_pause, (dcnt == DIM)};
      n_cmp++;
      if ({dir1, dir2, start1, start2, coin, coin_pend, pause, dim} !== exp) begin
        n_bad++;
        if (n_bad <= 20)
          $display("FAIL model: got %h expected %h (t=%0t)",
                   {dir1, dir2, start1, start2, coin, coin_pend, pause, dim}, exp, $time);
      end
    end
    if (coin === 1'b1) begin
      if (!coin_prev) begin
        n_pulses++;
        if (lo_len < GAP) bad_len++;
      end
      hi_len++; lo_len = 0;
    end else begin
      if (hi_len != 0 && hi_len != PUL) bad_len++;
      hi_len = 0; lo_len++;
    end
    coin_prev = coin;
    if (int'(coin_pend) > mx) mx = int'(coin_pend);
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input int b, input int hold, input int rel);
    if (b < 8) joy1[b] = 1'b1; else joy2[b-8] = 1'b1;
    wait_n(hold);
    if (b < 8) joy1[b] = 1'b0; else joy2[b-8] = 1'b0;
    wait_n(rel);
  endtask

  initial begin
    int p0, bl0, k;
    bit found;
    reset = 1'b1; joy1 = '0; joy2 = '0;
    hs_access = 1'b0; osd_status = 1'b0; osd_pause_en = 1'b0;
    wait_n(3);
    chk_en = 1;
    chk("reset_state", {dir1, dir2, start1, start2, coin, coin_pend, pause, dim}, 16'h0000);
    reset = 1'b0;
    wait_n(3);

    // 1: glitch rejected, held press accepted after 2+DEB+1 cycles
    press(0, 3, 12);
    chk("glitch_dir1", 16'(dir1), 16'h0);
    joy1[0] = 1'b1;
    wait_n(6);
    chk("dir1_cyc6", 16'(dir1), 16'h0);
    wait_n(1);
    chk("dir1_cyc7", 16'(dir1), 16'h1);
    wait_n(3);
    joy1[0] = 1'b0;
    wait_n(10);

    // 2: 4-way arbitration
    joy1[0] = 1'b1; wait_n(10);
    joy1[3] = 1'b1; wait_n(10);
    chk("right_then_up", 16'(dir1), 16'h8);
    joy1[3] = 1'b0; wait_n(10);
    chk("up_released", 16'(dir1), 16'h1);
    joy1[0] = 1'b0; wait_n(10);
    joy1[3] = 1'b1; joy1[1] = 1'b1; wait_n(10);
    chk("up_left_same", 16'(dir1), 16'h8);
    joy1 = '0; joy2[4] = 1'b1; wait_n(10);
    chk("start1_p2", {15'd0, start1}, 16'h1);
    joy2[4] = 1'b0; wait_n(10);

    // 3: three coins -> three well-formed pulses, queue drains
    p0 = n_pulses; bl0 = bad_len;
    press(6, 6, 6); press(14, 6, 6); press(6, 6, 6);
    wait_n(60);
    chk("coin_pulses", 16'(n_pulses - p0), 16'd3);
    chk("coin_shape", 16'(bad_len - bl0), 16'd0);
    chk("pend_drained", 16'(coin_pend), 16'd0);

    // 4: pause toggle, dim, hiscore pause
    press(15, 6, 6);
    chk("pause_on", {15'd0, pause}, 16'h1);
    wait_n(22);
    chk("dim_on", {15'd0, dim}, 16'h1);
    press(15, 6, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (pause === 1'b0) found = 1;
    end
    chk("pause_off", {15'd0, found}, 16'h1);
    tick();
    chk("dim_off", {15'd0, dim}, 16'h0);
    hs_access = 1'b1; tick();
    chk("hs_pause", {15'd0, pause}, 16'h1);
    hs_access = 1'b0; wait_n(3);

    // 5: OSD pause gating
    osd_status = 1'b1; wait_n(3);
    chk("osd_no_en", {15'd0, pause}, 16'h0);
    osd_pause_en = 1'b1; tick();
    chk("osd_en", {15'd0, pause}, 16'h1);
    osd_status = 1'b0; osd_pause_en = 1'b0; wait_n(3);

    // queue saturation, then reset in the middle of a pulse
    joy1[0] = 1'b1; hs_access = 1'b1;
    mx = 0;
    for (int i = 0; i < 24; i++) press(6, 5, 5);
    chk("pend_saturates", 16'(mx), 16'd7);
    found = 0; k = 0;
    while (!found && k < 300) begin
      tick(); k++;
      if (coin === 1'b1 && coin_pend == 3'd2) found = 1;
    end
    chk("wait_pend2", {15'd0, found}, 16'h1);
    reset = 1'b1; hs_access = 1'b0; tick();
    chk("rst_mid_pulse", {dir1, dir2, coin, coin_pend, pause}, 16'h0);
    reset = 1'b0; joy1 = '0;
    wait_n(5);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) begin
        k = $urandom_range(15);
        if (k < 8) joy1[k] = ~joy1[k]; else joy2[k-8] = ~joy2[k-8];
      end
      if ($urandom_range(63) == 0) hs_access = ~hs_access;
      if ($urandom_range(63) == 0) osd_status = ~osd_status;
      if ($urandom_range(63) == 0) osd_pause_en = ~osd_pause_en;
      reset = ($urandom_range(999) == 0);
      tick();
    end
    reset = 1'b0;
    wait_n(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
